// File: rtl/fifo_pkg.sv
// Shared async-FIFO constants and Gray-code helpers, used by both pointer domains.
package fifo_pkg;

  localparam int ADDRSIZE_DFLT = 4;
  localparam int DEPTH         = 1 << ADDRSIZE_DFLT;
  localparam int PTRW          = ADDRSIZE_DFLT + 1;

  // Helpers work on zero-extended 32-bit values, so any pointer width up to 32 fits.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_ctrl_if.sv
// Write-side bus between producer / read-domain pointer and the write pointer block.
interface wptr_full_ctrl_if
  import fifo_pkg::*;
#(
    parameter int ADDRSIZE = ADDRSIZE_DFLT
);
    // Handshake: a write is accepted on a wclk edge where winc=1 and wfull=0; winc while
    // wfull=1 is dropped and flagged in woverflow. There is no ready path back from winc.
    logic                winc;
    logic [ADDRSIZE:0]   rptr;
    logic                wovf_clr;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE:0]   wptr;
    logic                wfull;
    logic                walmost_full;
    logic [ADDRSIZE:0]   wfree;
    logic                woverflow;

    modport master (
        output winc, rptr, wovf_clr,
        input  waddr, wptr, wfull, walmost_full, wfree, woverflow
    );

    modport slave (
        input  winc, rptr, wovf_clr,
        output waddr, wptr, wfull, walmost_full, wfree, woverflow
    );
endinterface

// File: rtl/wptr_full_ctrl_sync_r2w.sv
// Two-flop synchronizer carrying the Gray read pointer into the write clock domain.
module sync_r2w
  import fifo_pkg::*;
#(
    parameter int WIDTH = PTRW
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] wq1_q;
    logic [WIDTH-1:0] wq2_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wq1_q <= '0;
            wq2_q <= '0;
        end else begin
            wq1_q <= d_i;
            wq2_q <= wq1_q;
        end
    end

    assign q_o = wq2_q;
endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer/flag generator: binary+Gray write pointer, full, almost-full,
// free-slot count and sticky overflow, all registered on wclk.
module wptr_full_ctrl
  import fifo_pkg::*;
#(
    parameter int ADDRSIZE     = ADDRSIZE_DFLT,
    parameter int AFULL_THRESH = 2
) (
    input logic              wclk,
    input logic              wrst_n,
    wptr_full_ctrl_if.slave  bus
);
    localparam int   PW        = ADDRSIZE + 1;
    localparam int   NSLOT     = 1 << ADDRSIZE;
    localparam logic AFULL_RST = (NSLOT <= AFULL_THRESH);

    logic [PW-1:0] wq2_rptr;
    logic [PW-1:0] wbin_q,  wbin_d;
    logic [PW-1:0] wptr_q,  wptr_d;
    logic [PW-1:0] wfree_q, wfree_d;
    logic          wfull_q, wfull_d;
    logic          wafull_q, wafull_d;
    logic          wovf_q,  wovf_d;
    logic          wpush;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] used;

    sync_r2w #(.WIDTH(PW)) u_sync_r2w (
        .clk_i  (wclk),
        .rst_ni (wrst_n),
        .d_i    (bus.rptr),
        .q_o    (wq2_rptr)
    );

    // Flags and count all use the pre-edge synchronized pointer, so they stay mutually consistent.
    always_comb begin
        wpush    = bus.winc & ~wfull_q;
        wbin_d   = wbin_q + {{(PW-1){1'b0}}, wpush};
        wptr_d   = PW'(bin2gray(32'(wbin_d)));
        rbin_s   = PW'(gray2bin(32'(wq2_rptr)));
        used     = wbin_d - rbin_s;
        wfree_d  = PW'(NSLOT) - used;
        wfull_d  = (wptr_d == {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]});
        wafull_d = (32'(wfree_d) <= 32'(AFULL_THRESH));
        wovf_d   = (bus.winc & wfull_q) | (wovf_q & ~bus.wovf_clr);
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wfree_q  <= PW'(NSLOT);
            wfull_q  <= 1'b0;
            wafull_q <= AFULL_RST;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wfree_q  <= wfree_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wovf_q   <= wovf_d;
        end
    end

    assign bus.waddr        = wbin_q[ADDRSIZE-1:0];
    assign bus.wptr         = wptr_q;
    assign bus.wfull        = wfull_q;
    assign bus.walmost_full = wafull_q;
    assign bus.wfree        = wfree_q;
    assign bus.woverflow    = wovf_q;
endmodule
